pos_sweep_eval: RTL and testbench
=================================

# pos_sweep_eval

Parametrised, sequential product-of-sums evaluator. It holds up to M programmable sum terms over N inputs and, on command, sweeps all 2^N input combinations in ascending order. Each (combination, result) pair is streamed out over a valid/ready handshake, and the full truth table and its ones-count are captured for readback. It sits beside the combinational PoS exercise blocks and replaces the hand-written exhaustive stimulus used to check them.

## Interface
- N, default 4: number of inputs; x[N-1] is the leftmost literal (a), x[0] the rightmost. Legal range 2..8.
- M, default 4: number of sum-term slots. Legal range 2..16.
- clk  in  1  clock, rising edge.
- rst_n  in  1  reset, asynchronous and active-low.
- cfg_we  in  1  writes term slot cfg_idx.
- cfg_idx  in  $clog2(M)  slot index.
- cfg_pos  in  N  uncomplemented-literal mask.
- cfg_neg  in  N  complemented-literal mask.
- start  in  1  begins a sweep.
- abort  in  1  ends a sweep early.
- busy  out  1  high while a sweep is running.
- done  out  1  one-cycle pulse when a sweep completes.
- out_valid  out  1  a result is present.
- out_ready  in  1  the consumer accepts the result.
- out_vec  out  N  current input combination.
- out_s  out  1  function value for out_vec.
- tt  out  2^N  truth table; bit k holds s for combination k.
- ones  out  N+1  number of set bits in tt.

## Operation
- Term j evaluates as OR over i of (pos[j][i] & x[i]) | (neg[j][i] & ~x[i]).
- A slot with pos = neg = 0 is disabled and evaluates to 1.
- out_s is the AND of all M terms. If every slot is disabled, out_s = 1.
- If pos[j][i] = neg[j][i] = 1, term j is 1.
- The FSM has three states: IDLE, RUN, DONE.
  - IDLE → RUN when start = 1. On entry: vec = 0, tt = 0, ones = 0.
  - In RUN, out_valid = 1. On each accepted transfer (out_valid & out_ready): tt[vec] = out_s; ones increments by out_s; vec increments.
  - When the accepted vec equals 2^N-1, RUN → DONE.
  - DONE → IDLE unconditionally after one cycle; done = 1 in DONE.
- abort = 1 in RUN returns to IDLE on the next edge.
  - The partial tt and ones are kept.
  - done is not pulsed.
  - abort has priority over a simultaneous accepted transfer, so that transfer is not recorded.
- A start while in RUN or DONE is ignored.
- A cfg_we while in RUN or DONE is ignored, so the masks stay frozen for the whole sweep. cfg_we in IDLE takes effect on the next edge.
- start and cfg_we asserted together in IDLE: the write lands and the sweep uses the new value.
- busy = 1 in RUN and DONE.

## Timing
- Reset values: FSM = IDLE; all masks = 0; vec = 0; tt = 0; ones = 0; busy = done = out_valid = 0.
- out_s follows out_vec and the masks; it is 1 at reset, since all slots are disabled.
- Reset mid-sweep returns everything to reset values immediately.
- If start is sampled at edge 0, out_valid rises after edge 0 with out_vec = 0.
- With out_ready held at 1, one combination is accepted per cycle: out_vec = k during cycle k+1. done is high during cycle 2^N+1, and busy falls after that.
- While out_valid = 1 and out_ready = 0, out_vec and out_s hold stable. out_valid never drops without a transfer, except on abort or reset.
- tt and ones are stable from the done pulse until the next accepted start.
- vec uses N+1 bits internally, so the last index does not wrap.

## Structure
- Package pos_sweep_pkg holds:
  - the state enum (IDLE, RUN, DONE);
  - localparams NCOMB = 2**N and IDXW = $clog2(M);
  - a term struct with pos and neg fields.
- Sub-module pos_eval is purely combinational. It takes the mask arrays and vec and produces out_s. This lets it be checked exhaustively on its own.
- The top level holds the mask register file, the FSM, the counter and the tt/ones accumulators.

## Test plan
- Program slots 0..3, with N=4, M=4, out_ready = 1:
  - slot 0 (a|c): pos=1010, neg=0000;
  - slot 1 (c|~d): pos=0010, neg=0001;
  - slot 2 (~a|b): pos=0100, neg=1000;
  - slot 3 (b|~d): pos=0100, neg=0001.
  - Then start. Required: out_s = 1 exactly for vec ∈ {2, 6, 7, 12, 14, 15}; tt = 16'hD0C4; ones = 6; done in cycle 17.
- All slots disabled, start → tt = 16'hFFFF, ones = 16.
- Same program as the first case, with out_ready toggling 1,0,0,1,…:
  - out_vec and out_s hold through stalls;
  - the final tt = 16'hD0C4;
  - done arrives only after the 16th transfer.
- Abort at vec = 5, with transfers of vec 0..4 already accepted, using the first-case program:
  - FSM returns to IDLE with no done;
  - tt = 16'h0004, ones = 1;
  - a new start clears tt before the sweep.
- During RUN, issue cfg_we to slot 0 with pos=0000, neg=0000, then a second start. Both are ignored, and the final tt = 16'hD0C4.
- Assert rst_n = 0 mid-sweep (vec = 9). Required: out_valid, busy and done go to 0 at once; tt = 0; ones = 0; masks cleared. The next sweep without reprogramming gives tt = 16'hFFFF.

Source files
------------

// File: rtl/pos_sweep_pkg.sv
// Shared types and default sizing for the product-of-sums sweep evaluator.
package pos_sweep_pkg;

  localparam int unsigned N_MAX = 8;
  localparam int unsigned N_DEF = 4;
  localparam int unsigned M_DEF = 4;
  localparam int unsigned NCOMB = 2 ** N_DEF;
  localparam int unsigned IDXW  = $clog2(M_DEF);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  // Literal masks are stored at the widest legal N; unused upper bits stay zero.
  typedef struct packed {
    logic [N_MAX-1:0] pos;
    logic [N_MAX-1:0] neg;
  } term_t;

endpackage

// File: rtl/pos_eval.sv
// Combinational product-of-sums: AND over all enabled sum terms for one input vector.
module pos_eval
  import pos_sweep_pkg::*;
#(
  parameter int unsigned N = N_DEF,
  parameter int unsigned M = M_DEF
) (
  input  term_t      terms [M],
  input  logic [N-1:0] vec,
  output logic       s
);

  logic [N_MAX-1:0] x_ext;

  assign x_ext = N_MAX'(vec);

  // A slot with no literals is disabled and must not pull the product low.
  always_comb begin
    s = 1'b1;
    for (int j = 0; j < int'(M); j++) begin
      if ((terms[j].pos | terms[j].neg) != '0) begin
        s = s & (|((terms[j].pos & x_ext) | (terms[j].neg & ~x_ext)));
      end
    end
  end

endmodule

// File: rtl/pos_sweep_eval.sv
// Sweeps all 2^N input combinations through the programmed PoS function, streaming results and capturing the truth table.
module pos_sweep_eval
  import pos_sweep_pkg::*;
#(
  parameter int unsigned N = N_DEF,
  parameter int unsigned M = M_DEF
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 cfg_we,
  input  logic [$clog2(M)-1:0] cfg_idx,
  input  logic [N-1:0]         cfg_pos,
  input  logic [N-1:0]         cfg_neg,
  input  logic                 start,
  input  logic                 abort,
  output logic                 busy,
  output logic                 done,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [N-1:0]         out_vec,
  output logic                 out_s,
  output logic [2**N-1:0]      tt,
  output logic [N:0]           ones
);

  localparam int unsigned COMB_N = 2 ** N;
  localparam int unsigned VW     = N + 1;

  state_e          state_q, state_d;
  logic [N:0]      vec_q, vec_d;
  logic [2**N-1:0] tt_d;
  logic [N:0]      ones_d;
  term_t           terms_q [M];
  logic            cfg_ok;
  logic            accept;

  assign cfg_ok  = cfg_we && (state_q == ST_IDLE) && (32'(cfg_idx) < M);
  assign accept  = out_valid & out_ready;
  assign out_vec = vec_q[N-1:0];

  // Mask register file; frozen outside IDLE so a sweep sees one consistent function.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int j = 0; j < int'(M); j++) begin
        terms_q[j] <= '0;
      end
    end else if (cfg_ok) begin
      terms_q[cfg_idx] <= '{pos: N_MAX'(cfg_pos), neg: N_MAX'(cfg_neg)};
    end
  end

  pos_eval #(.N(N), .M(M)) u_eval (
    .terms (terms_q),
    .vec   (out_vec),
    .s     (out_s)
  );

  always_comb begin
    state_d = state_q;
    vec_d   = vec_q;
    tt_d    = tt;
    ones_d  = ones;
    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d = ST_RUN;
          vec_d   = '0;
          tt_d    = '0;
          ones_d  = '0;
        end
      end
      ST_RUN: begin
        // Abort wins over a same-cycle transfer, which is then dropped.
        if (abort) begin
          state_d = ST_IDLE;
        end else if (accept) begin
          tt_d[vec_q[N-1:0]] = out_s;
          ones_d             = ones + VW'(out_s);
          vec_d              = vec_q + VW'(1);
          if (vec_q == VW'(COMB_N - 1)) begin
            state_d = ST_DONE;
          end
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      vec_q     <= '0;
      tt        <= '0;
      ones      <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      out_valid <= 1'b0;
    end else begin
      state_q   <= state_d;
      vec_q     <= vec_d;
      tt        <= tt_d;
      ones      <= ones_d;
      busy      <= (state_d != ST_IDLE);
      done      <= (state_d == ST_DONE);
      out_valid <= (state_d == ST_RUN);
    end
  end

endmodule

// File: tb/tb_pos_sweep_eval.sv
// Self-checking bench for pos_sweep_eval: table-driven sweeps, random programs and hand-written corner sequences.
module tb_pos_sweep_eval;

  localparam int unsigned N  = 4;
  localparam int unsigned M  = 4;
  localparam int unsigned NC = 16;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         cfg_we = 1'b0;
  logic [1:0]   cfg_idx = '0;
  logic [N-1:0] cfg_pos = '0;
  logic [N-1:0] cfg_neg = '0;
  logic         start = 1'b0;
  logic         abort = 1'b0;
  logic         busy, done, out_valid;
  logic         out_ready = 1'b0;
  logic [N-1:0] out_vec;
  logic         out_s;
  logic [NC-1:0] tt;
  logic [N:0]   ones;

  int n_pass = 0;
  int n_chk  = 0;

  logic [3:0] mp [4];
  logic [3:0] mn [4];

  typedef struct {
    logic [15:0] pv;
    logic [15:0] nv;
    logic [15:0] exp_tt;
    int          exp_ones;
    int          mode;
  } vec_t;

  vec_t tbl [7];

  always #5 clk = ~clk;

  pos_sweep_eval #(.N(N), .M(M)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .cfg_we    (cfg_we),
    .cfg_idx   (cfg_idx),
    .cfg_pos   (cfg_pos),
    .cfg_neg   (cfg_neg),
    .start     (start),
    .abort     (abort),
    .busy      (busy),
    .done      (done),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_vec   (out_vec),
    .out_s     (out_s),
    .tt        (tt),
    .ones      (ones)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // Reference: each sum term is true if any selected literal is true; empty terms are ignored.
  function automatic logic model_s(input int x);
    logic r;
    logic any;
    r = 1'b1;
    for (int j = 0; j < 4; j++) begin
      if (mp[j] != 4'd0 || mn[j] != 4'd0) begin
        any = 1'b0;
        for (int i = 0; i < 4; i++) begin
          if ((mp[j][i] && ((x >> i) & 1) == 1) || (mn[j][i] && ((x >> i) & 1) == 0)) any = 1'b1;
        end
        if (!any) r = 1'b0;
      end
    end
    return r;
  endfunction

  function automatic logic [15:0] model_tt();
    logic [15:0] t;
    t = '0;
    for (int x = 0; x < 16; x++) t[x] = model_s(x);
    return t;
  endfunction

  function automatic int popcount16(input logic [15:0] v);
    int c;
    c = 0;
    for (int i = 0; i < 16; i++) c += int'(v[i]);
    return c;
  endfunction

  task automatic program_all(input logic [15:0] pv, input logic [15:0] nv);
    for (int j = 0; j < 4; j++) begin
      cfg_we  = 1'b1;
      cfg_idx = 2'(j);
      cfg_pos = pv[4*j +: 4];
      cfg_neg = nv[4*j +: 4];
      mp[j]   = pv[4*j +: 4];
      mn[j]   = nv[4*j +: 4];
      @(posedge clk); #1;
    end
    cfg_we = 1'b0;
  endtask

  // mode 0: ready held high; 1: ready pattern 1,0,0,...; 2: random ready.
  task automatic run_sweep(input string tag, input int mode, input bit inject,
                           input logic [15:0] exp_tt, input int exp_ones);
    int  k;
    int  cyc;
    int  rc;
    bit  rdy;
    bit  seen_done;
    k = 0; rc = 0; seen_done = 0;
    start = 1'b1;
    out_ready = (mode != 1) ? 1'b1 : 1'b0;
    @(posedge clk); #1;
    start = 1'b0;
    cyc = 1;
    chk({tag, " tt cleared on start"}, 32'(tt), 32'h0);
    chk({tag, " ones cleared on start"}, 32'(ones), 32'h0);
    while (!seen_done && cyc < 200) begin
      if (done) begin
        seen_done = 1;
        if (mode == 0) chk({tag, " done cycle"}, 32'(cyc), 32'(NC + 1));
        chk({tag, " transfers before done"}, 32'(k), 32'(NC));
        chk({tag, " tt"}, 32'(tt), 32'(exp_tt));
        chk({tag, " ones"}, 32'(ones), 32'(exp_ones));
        chk({tag, " busy in done"}, 32'(busy), 32'h1);
        chk({tag, " valid low in done"}, 32'(out_valid), 32'h0);
      end else begin
        chk({tag, " valid"}, 32'(out_valid), 32'h1);
        chk({tag, " out_vec"}, 32'(out_vec), 32'(k));
        chk({tag, " out_s"}, 32'(out_s), 32'(model_s(k)));
        case (mode)
          0: rdy = 1'b1;
          1: rdy = (rc % 3 == 0);
          default: rdy = 1'($urandom_range(1, 0));
        endcase
        rc++;
        if (inject && cyc == 5) begin
          cfg_we  = 1'b1;
          cfg_idx = 2'd0;
          cfg_pos = 4'd0;
          cfg_neg = 4'd0;
          start   = 1'b1;
        end
        out_ready = rdy;
        @(posedge clk); #1;
        cyc++;
        if (rdy && out_valid !== 1'bx) k++;
        cfg_we = 1'b0;
        start  = 1'b0;
      end
    end
    if (!seen_done) chk({tag, " done timeout"}, 32'h0, 32'h1);
    @(posedge clk); #1;
    chk({tag, " busy falls after done"}, 32'(busy), 32'h0);
    chk({tag, " done is one pulse"}, 32'(done), 32'h0);
    chk({tag, " tt holds after done"}, 32'(tt), 32'(exp_tt));
    out_ready = 1'b0;
  endtask

  initial begin
    logic [15:0] pv;
    logic [15:0] nv;
    logic [15:0] et;
    for (int j = 0; j < 4; j++) begin mp[j] = '0; mn[j] = '0; end

    tbl[0] = '{16'h442A, 16'h1810, 16'hD0C4,  6, 0};
    tbl[1] = '{16'h0000, 16'h0000, 16'hFFFF, 16, 0};
    tbl[2] = '{16'h442A, 16'h1810, 16'hD0C4,  6, 1};
    tbl[3] = '{16'h0001, 16'h0000, 16'hAAAA,  8, 0};
    tbl[4] = '{16'h0008, 16'h0008, 16'hFFFF, 16, 0};
    tbl[5] = '{16'h0000, 16'h000F, 16'h7FFF, 15, 0};
    tbl[6] = '{16'h0030, 16'h0000, 16'hEEEE, 12, 2};

    // Reset state.
    repeat (2) @(posedge clk);
    #1;
    chk("reset busy", 32'(busy), 32'h0);
    chk("reset done", 32'(done), 32'h0);
    chk("reset out_valid", 32'(out_valid), 32'h0);
    chk("reset tt", 32'(tt), 32'h0);
    chk("reset ones", 32'(ones), 32'h0);
    chk("reset out_s", 32'(out_s), 32'h1);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;

    for (int t = 0; t < 7; t++) begin
      program_all(tbl[t].pv, tbl[t].nv);
      run_sweep($sformatf("tbl%0d", t), tbl[t].mode, 1'b0, tbl[t].exp_tt, tbl[t].exp_ones);
    end

    // Random programs, random ready, against the reference model.
    for (int r = 0; r < 6; r++) begin
      pv = 16'($urandom) & 16'($urandom);
      nv = 16'($urandom) & 16'($urandom);
      program_all(pv, nv);
      et = model_tt();
      run_sweep($sformatf("rand%0d", r), 2, 1'b0, et, popcount16(et));
    end

    // Abort at vec 5 with the abort cycle also offering a transfer.
    program_all(16'h442A, 16'h1810);
    start = 1'b1; out_ready = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (5) begin @(posedge clk); #1; end
    chk("abort pre out_vec", 32'(out_vec), 32'd5);
    abort = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0;
    chk("abort busy", 32'(busy), 32'h0);
    chk("abort valid", 32'(out_valid), 32'h0);
    chk("abort done", 32'(done), 32'h0);
    chk("abort tt", 32'(tt), 32'h0004);
    chk("abort ones", 32'(ones), 32'd1);
    @(posedge clk); #1;
    chk("abort no late done", 32'(done), 32'h0);
    chk("abort tt kept", 32'(tt), 32'h0004);
    run_sweep("after abort", 0, 1'b0, 16'hD0C4, 6);

    // Config write and second start during RUN are ignored.
    run_sweep("frozen cfg", 0, 1'b1, 16'hD0C4, 6);

    // Reset mid-sweep at vec 9.
    start = 1'b1; out_ready = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (9) begin @(posedge clk); #1; end
    chk("pre reset out_vec", 32'(out_vec), 32'd9);
    rst_n = 1'b0;
    #1;
    chk("midreset valid", 32'(out_valid), 32'h0);
    chk("midreset busy", 32'(busy), 32'h0);
    chk("midreset done", 32'(done), 32'h0);
    chk("midreset tt", 32'(tt), 32'h0);
    chk("midreset ones", 32'(ones), 32'h0);
    chk("midreset out_s", 32'(out_s), 32'h1);
    @(negedge clk);
    rst_n = 1'b1;
    for (int j = 0; j < 4; j++) begin mp[j] = '0; mn[j] = '0; end
    @(posedge clk); #1;
    run_sweep("after reset", 0, 1'b0, 16'hFFFF, 16);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
